aes_wb_arbiter: RTL and testbench

//  Two-master Wishbone classic arbiter sharing the single AES Wishbone slave in the user area.

---
 rtl/aes_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_aes_wb_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of the single AES slave.
// Master 0 is the management SoC port, master 1 the user-area sequencer.
// Ownership is round-robin and held for the owner's whole cyc. A watchdog
// answers the owner with err when the slave leaves a strobe unacked.
module aes_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // master 0: management SoC
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  // master 1: user-area sequencer
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  // shared slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  // watchdog event
  output logic            timeout_o
);

  localparam int SW = DW / 8;
  // the counter must be able to hold TIMEOUT itself (expiry value)
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            last_r;       // index of the most recent grant
  logic            last_nxt_s;
  logic [CW-1:0]   cnt_r;        // consecutive unacked strobe cycles
  logic [CW-1:0]   cnt_nxt_s;

  logic            req0_s;
  logic            req1_s;
  logic            timeout_s;

  logic            own_cyc_s;
  logic            own_stb_s;
  logic            own_we_s;
  logic [SW-1:0]   own_sel_s;
  logic [AW-1:0]   own_adr_s;
  logic [DW-1:0]   own_dat_s;

  assign req0_s = m0_cyc_i & m0_stb_i;
  assign req1_s = m1_cyc_i & m1_stb_i;

  // Grant selection: single requester wins, a tie goes to the master that
  // did not own the bus last; an owner keeps the bus until it drops cyc.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (req0_s && req1_s) begin
          if (last_r) begin
            state_nxt_s = GNT0;
            last_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = GNT1;
            last_nxt_s  = 1'b1;
          end
        end else if (req0_s) begin
          state_nxt_s = GNT0;
          last_nxt_s  = 1'b0;
        end else if (req1_s) begin
          state_nxt_s = GNT1;
          last_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0: begin
        if (m0_cyc_i) begin
          state_nxt_s = GNT0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT1: begin
        if (m1_cyc_i) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and watchdog registers; last starts at 1 so
  // master 0 wins the first tie after reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Pick the owner's request signals; nothing is selected while idle.
  always_comb begin
    own_cyc_s = 1'b0;
    own_stb_s = 1'b0;
    own_we_s  = 1'b0;
    own_sel_s = '0;
    own_adr_s = '0;
    own_dat_s = '0;
    case (state_r)
      GNT0: begin
        own_cyc_s = m0_cyc_i;
        own_stb_s = m0_stb_i;
        own_we_s  = m0_we_i;
        own_sel_s = m0_sel_i;
        own_adr_s = m0_adr_i;
        own_dat_s = m0_dat_i;
      end
      GNT1: begin
        own_cyc_s = m1_cyc_i;
        own_stb_s = m1_stb_i;
        own_we_s  = m1_we_i;
        own_sel_s = m1_sel_i;
        own_adr_s = m1_adr_i;
        own_dat_s = m1_dat_i;
      end
      IDLE: begin
        own_cyc_s = 1'b0;
      end
      default: begin
        own_cyc_s = 1'b0;
      end
    endcase
  end

  // Drive the slave with the owner's signals gated by the owner's cyc; the
  // strobe is withdrawn in the watchdog error cycle so the slave cannot ack it.
  always_comb begin
    s_cyc_o = own_cyc_s;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own_cyc_s) begin
      s_stb_o = own_stb_s & ~timeout_s;
      s_we_o  = own_we_s;
      s_sel_o = own_sel_s;
      s_adr_o = own_adr_s;
      s_dat_o = own_dat_s;
    end else begin
      s_stb_o = 1'b0;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

      // Expiry is a registered condition, so err never depends on s_ack_i.
      assign timeout_s = (state_r != IDLE) && (cnt_r == LIMIT);

      // Count unacked strobe cycles; any ack, idle bus or dropped strobe
      // restarts the count, as does the error cycle itself.
      always_comb begin
        cnt_nxt_s = '0;
        if (timeout_s) begin
          cnt_nxt_s = '0;
        end else if (s_stb_o && !s_ack_i) begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end else begin
          cnt_nxt_s = '0;
        end
      end
    end else begin : g_no_wdog
      assign timeout_s = 1'b0;
      assign cnt_nxt_s = '0;
    end
  endgenerate

  assign timeout_o = timeout_s;

  // Return path: only the owner sees ack/err/data; acks that arrive while
  // no strobe is presented (late or spurious) are dropped.
  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state_r)
      GNT0: begin
        m0_ack_o = s_ack_i & s_stb_o;
        m0_err_o = timeout_s;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        m1_ack_o = s_ack_i & s_stb_o;
        m1_err_o = timeout_s;
        m1_dat_o = s_dat_i;
      end
      IDLE: begin
        m0_ack_o = 1'b0;
      end
      default: begin
        m0_ack_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_wb_arbiter.sv
// Self-checking bench for aes_wb_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a bus-ownership reference model.
module tb_aes_wb_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int VW  = 140;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_cyc [2];
  logic            m_stb [2];
  logic            m_we  [2];
  logic [3:0]      m_sel [2];
  logic [AW-1:0]   m_adr [2];
  logic [DW-1:0]   m_dat [2];
  logic            s_ack;
  logic [DW-1:0]   s_dat;

  logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [DW-1:0]   m0_dat_o, m1_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]      s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the bus, who was granted last, and how long
  // the current strobe has gone unanswered
  int              own_m;
  int              last_m;
  int              wait_m;
  bit              to_m;
  bit              stb_m;
  bit              exp_ack [2];
  bit              exp_err [2];
  logic [VW-1:0]   exp_v;

  aes_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_cyc_i (m_cyc[0]), .m0_stb_i (m_stb[0]), .m0_we_i (m_we[0]),
    .m0_sel_i (m_sel[0]), .m0_adr_i (m_adr[0]), .m0_dat_i (m_dat[0]),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_dat_o (m0_dat_o),
    .m1_cyc_i (m_cyc[1]), .m1_stb_i (m_stb[1]), .m1_we_i (m_we[1]),
    .m1_sel_i (m_sel[1]), .m1_adr_i (m_adr[1]), .m1_dat_i (m_dat[1]),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_dat_o (m1_dat_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
    .s_ack_i  (s_ack),    .s_dat_i  (s_dat),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
            m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o, timeout_o};
  endfunction

  // Expected outputs for the current inputs and model state.
  task automatic model_eval();
    logic sc, swe;
    logic [3:0] ssel;
    logic [31:0] sadr, sdat, d0, d1;
    int o;
    sc = 1'b0; swe = 1'b0; ssel = 4'h0; sadr = 32'h0; sdat = 32'h0;
    d0 = 32'h0; d1 = 32'h0;
    to_m = 1'b0; stb_m = 1'b0;
    exp_ack[0] = 1'b0; exp_ack[1] = 1'b0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    if (own_m >= 0) begin
      o = own_m;
      to_m  = (wait_m == TMO);
      sc    = m_cyc[o];
      stb_m = m_cyc[o] && m_stb[o] && !to_m;
      if (sc) begin
        swe = m_we[o]; ssel = m_sel[o]; sadr = m_adr[o]; sdat = m_dat[o];
      end
      exp_ack[o] = s_ack && stb_m;
      exp_err[o] = to_m;
      if (o == 0) d0 = s_dat; else d1 = s_dat;
    end
    exp_v = {sc, stb_m, swe, ssel, sadr, sdat,
             exp_ack[0], exp_err[0], d0, exp_ack[1], exp_err[1], d1, to_m};
  endtask

  // Advance the model across one rising edge.
  task automatic model_update();
    bit r0, r1;
    if (rst) begin
      own_m = -1; last_m = 1; wait_m = 0;
    end else if (own_m < 0) begin
      r0 = m_cyc[0] && m_stb[0];
      r1 = m_cyc[1] && m_stb[1];
      if (r0 && r1)  own_m = 1 - last_m;
      else if (r0)   own_m = 0;
      else if (r1)   own_m = 1;
      if (own_m >= 0) last_m = own_m;
      wait_m = 0;
    end else begin
      if (to_m)                 wait_m = 0;
      else if (stb_m && !s_ack) wait_m = wait_m + 1;
      else                      wait_m = 0;
      if (!m_cyc[own_m]) own_m = -1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_eval();
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
      m_sel[n] = 4'h0; m_adr[n] = 32'h0; m_dat[n] = 32'h0;
    end
    s_ack = 1'b0;
    s_dat = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1; s_ack = 1'b1;
    advance();
    advance();
    settle();
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++; $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_v);
    end
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL reset_zero: got %h expected all zero", obs_vec());
    end
    advance();
    rst = 1'b0;
    idle_inputs();
    advance();
  endtask

  task automatic test_single_write();
    int rise = -1, acks0 = 0, acks1 = 0;
    idle_inputs();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hF;
    m_adr[0] = 32'h3000_0000; m_dat[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      s_ack = (i == 3);
      if (i == 4) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL single_write c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      if (s_cyc_o && rise < 0) rise = i;
      acks0 += int'(m0_ack_o);
      acks1 += int'(m1_ack_o);
      advance();
    end
    checks++;
    if (rise !== 1) begin errors++; $display("FAIL write_cyc_latency: got %0d expected 1", rise); end
    checks++;
    if (acks0 !== 1) begin errors++; $display("FAIL write_m0_acks: got %0d expected 1", acks0); end
    checks++;
    if (acks1 !== 0) begin errors++; $display("FAIL write_m1_acks: got %0d expected 0", acks1); end
  endtask

  task automatic test_tie_after_reset();
    idle_inputs();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    m_adr[0] = 32'h3000_0004; m_adr[1] = 32'h3000_0008;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_ack = (i == 1) || (i == 4);
      if (i == 2) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      if (i == 5) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL tie c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      if (i == 1) begin
        checks++;
        if (s_adr_o !== 32'h3000_0004 || m0_ack_o !== 1'b1) begin
          errors++; $display("FAIL tie_m0_first: adr %h ack %b expected 30000004 1", s_adr_o, m0_ack_o);
        end
      end
      if (i == 3) begin
        checks++;
        if (s_cyc_o !== 1'b0) begin
          errors++; $display("FAIL tie_turnaround: s_cyc %b expected 0", s_cyc_o);
        end
      end
      if (i == 4) begin
        checks++;
        if (s_adr_o !== 32'h3000_0008 || m1_ack_o !== 1'b1) begin
          errors++; $display("FAIL tie_m1_next: adr %h ack %b expected 30000008 1", s_adr_o, m1_ack_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    bit term [2];
    int order [$];
    idle_inputs();
    term[0] = 1'b0; term[1] = 1'b0;
    m_adr[0] = 32'h3000_0020; m_adr[1] = 32'h3000_0024;
    s_dat = 32'h1234_5678;
    for (int i = 0; i < 60; i++) begin
      for (int n = 0; n < 2; n++) begin
        m_cyc[n] = !term[n];
        m_stb[n] = !term[n];
      end
      s_ack = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL b2b c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      if (m0_ack_o || m0_err_o) order.push_back(0);
      if (m1_ack_o || m1_err_o) order.push_back(1);
      if (m0_ack_o) begin
        checks++;
        if (m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h0) begin
          errors++; $display("FAIL b2b_dat0: m0 %h m1 %h expected 12345678 0", m0_dat_o, m1_dat_o);
        end
      end
      if (m1_ack_o) begin
        checks++;
        if (m1_dat_o !== 32'h1234_5678 || m0_dat_o !== 32'h0) begin
          errors++; $display("FAIL b2b_dat1: m1 %h m0 %h expected 12345678 0", m1_dat_o, m0_dat_o);
        end
      end
      term[0] = exp_ack[0] || exp_err[0];
      term[1] = exp_ack[1] || exp_err[1];
      advance();
    end
    checks++;
    if (order.size() < 4) begin
      errors++; $display("FAIL b2b_count: got %0d grants expected at least 4", order.size());
    end else begin
      if (order[0] !== 0) begin
        errors++; $display("FAIL b2b_first: got M%0d expected M0", order[0]);
      end
      for (int k = 1; k < order.size(); k++) begin
        checks++;
        if (order[k] === order[k-1]) begin
          errors++; $display("FAIL b2b_alternate k%0d: got M%0d twice", k, order[k]);
        end
      end
    end
    idle_inputs();
    advance();
    advance();
  endtask

  task automatic test_timeout();
    bit done = 1'b0;
    int err_at = -1, n_err = 0, n_stb = 0, n_ack = 0;
    logic stb_at_err = 1'bx, to_at_err = 1'bx;
    idle_inputs();
    m_adr[1] = 32'h3000_0010;
    for (int i = 0; i < 14; i++) begin
      m_cyc[1] = !done;
      m_stb[1] = !done;
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL timeout c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      if (s_stb_o) n_stb++;
      if (m0_ack_o || m1_ack_o) n_ack++;
      if (m1_err_o) begin
        n_err++;
        if (err_at < 0) begin err_at = i; stb_at_err = s_stb_o; to_at_err = timeout_o; end
      end
      if (exp_err[1]) done = 1'b1;
      advance();
    end
    checks++;
    if (err_at !== 9) begin errors++; $display("FAIL timeout_cycle: got %0d expected 9", err_at); end
    checks++;
    if (to_at_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", to_at_err); end
    checks++;
    if (stb_at_err !== 1'b0) begin errors++; $display("FAIL timeout_stb: got %b expected 0", stb_at_err); end
    checks++;
    if (n_err !== 1 || n_ack !== 0 || n_stb !== 8) begin
      errors++; $display("FAIL timeout_counts: err %0d ack %0d stb %0d expected 1 0 8", n_err, n_ack, n_stb);
    end
  endtask

  task automatic test_block();
    int acks0 = 0, first1 = -1;
    logic [31:0] adr_at_grant = 32'hx;
    idle_inputs();
    m_adr[0] = 32'h3000_0030; m_adr[1] = 32'h3000_0034;
    for (int i = 0; i < 10; i++) begin
      m_cyc[0] = (i <= 4); m_stb[0] = (i <= 4);
      m_cyc[1] = (i >= 1) && (i <= 7); m_stb[1] = m_cyc[1];
      s_ack = (i <= 4) || (i == 7);
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL block c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      acks0 += int'(m0_ack_o);
      if (m1_ack_o && first1 < 0) begin first1 = i; adr_at_grant = s_adr_o; end
      advance();
    end
    checks++;
    if (acks0 !== 4) begin errors++; $display("FAIL block_beats: got %0d expected 4", acks0); end
    checks++;
    if (first1 !== 7 || adr_at_grant !== 32'h3000_0034) begin
      errors++; $display("FAIL block_m1_grant: cycle %0d adr %h expected 7 30000034", first1, adr_at_grant);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    m_adr[0] = 32'h3000_0040; m_adr[1] = 32'h3000_0044;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_dat[0] = 32'hCAFE_0001;
    for (int i = 0; i < 7; i++) begin
      rst = (i == 2) || (i == 3);
      s_ack = (i >= 3);
      if (i >= 3) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      end
      if (i == 6) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL rst_mid c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (obs_vec() !== {VW{1'b0}}) begin
          errors++; $display("FAIL rst_mid_zero c%0d: got %h expected all zero", i, obs_vec());
        end
      end
      if (i == 5) begin
        checks++;
        if (s_adr_o !== 32'h3000_0040 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
          errors++; $display("FAIL rst_mid_tie: adr %h ack0 %b ack1 %b expected 30000040 1 0",
                             s_adr_o, m0_ack_o, m1_ack_o);
        end
      end
      advance();
    end
    rst = 1'b0;
    idle_inputs();
    advance();
    advance();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[n] = !m_cyc[n];
        m_stb[n] = m_cyc[n] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
        m_we[n]  = $urandom_range(0, 1) != 0;
        m_sel[n] = 4'($urandom_range(0, 15));
        m_adr[n] = $urandom;
        m_dat[n] = $urandom;
      end
      s_ack = ($urandom_range(0, 3) == 0);
      s_dat = $urandom;
      settle();
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL random c%0d: got %h expected %h", i, obs_vec(), exp_v);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    own_m = -1; last_m = 1; wait_m = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_tie_after_reset();
    test_back_to_back();
    test_timeout();
    test_block();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
